update_knn_topk: RTL and testbench
==================================

# update_knn_topk

Streaming top-K nearest-neighbour tracker that sits directly downstream of the `update_knn11` 17×15 unsigned multiplier stage. It consumes one 32-bit unsigned distance product per beat, tagged with a training label, and keeps the K smallest distances seen in the current query frame as a sorted table. When the frame ends it presents the sorted table to the voting stage, holding it until that stage accepts it.

## Interface
- `K`, 3, number of nearest neighbours kept; 1..8.
- `DIST_W`, 32, distance width; matches the multiplier product width.
- `LABEL_W`, 4, training label width.
- `ap_clk`  in  1  rising-edge clock.
- `ap_rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  distance beat valid.
- `in_ready`  out  1  block can accept a beat. Upstream drives the multiplier `ce` from `in_ready`.
- `in_dist`  in  DIST_W  unsigned distance.
- `in_label`  in  LABEL_W  label of this training sample.
- `in_last`  in  1  final beat of the query frame.
- `out_valid`  out  1  sorted result available.
- `out_ready`  in  1  downstream accepts result.
- `out_dist`  out  K*DIST_W  slot i at bits [i*DIST_W +: DIST_W]; slot 0 is the smallest.
- `out_label`  out  K*LABEL_W  labels, same slot order as `out_dist`.
- `out_count`  out  4  number of valid slots, 0..K.

## Operation
- FSM has two states: RUN and EMIT. Reset enters RUN.
- **RUN**
  - `in_ready`=1 and `out_valid`=0.
  - Accept a beat when `in_valid` && `in_ready`.
  - Insertion position p = number of valid slots with `dist <= in_dist`.
  - Ties therefore place the new entry after existing equal entries, so the older sample wins the tie.
  - If p<K: slots p..K-2 shift to p+1..K-1, the new entry is written to slot p, and the old slot K-1 is dropped.
  - If p==K: the beat is discarded.
  - `count` increments by 1 per accepted beat and saturates at K.
  - Only valid slots (index < `count`) take part in the comparison, so a distance of 0xFFFF_FFFF is still inserted while the table is not full.
  - An accepted beat with `in_last`=1 is inserted first; the FSM then moves to EMIT.
- **EMIT**
  - `in_ready`=0 and `out_valid`=1.
  - `out_dist`, `out_label` and `out_count` hold stable until the handshake completes.
  - On `out_valid` && `out_ready`, the table clears: all distances all-ones, all labels 0, `count` 0. The FSM returns to RUN.
- Arithmetic: comparisons are unsigned over the full DIST_W width. There is no truncation or rounding.
- Reset, asserted at any time including mid-frame or during EMIT:
  - FSM=RUN, `count`=0, distances all-ones, labels 0.
  - `out_valid`=0, `in_ready` goes to 1 after deassertion.
  - A partially built frame is discarded.

## Timing
- Insertion is single-cycle: a beat accepted at edge n is visible in the table after edge n.
- Result latency: the last beat accepted at edge n gives `out_valid`=1 in the cycle after edge n.
- Throughput is one beat per cycle in RUN.
- Each frame costs at least one bubble cycle: the EMIT cycle, which lasts until `out_ready`.
- `in_ready` depends only on the FSM state, never combinationally on `in_valid` or `out_ready`.
- `out_valid` is registered and never depends combinationally on `out_ready`.
- `out_*` change only on the edge that completes the handshake.
- Output reset values:
  - `in_ready`=1 (held at 0 while `ap_rst_n` is asserted).
  - `out_valid`=0, `out_count`=0.
  - `out_dist` all-ones, `out_label`=0.

## Structure
- Shared package `update_knn_pkg` holds:
  - `K`, `DIST_W` and `LABEL_W` defaults,
  - state enum {RUN, EMIT},
  - the all-ones distance constant `DIST_EMPTY`.
- One sub-module, `update_knn_topk_slot`, is replicated K times. Per slot it:
  - compares against `in_dist` and qualifies the result with slot validity,
  - selects among hold / take-from-previous-slot / take-new,
  - gets its take-new/shift control from its own compare bit and the previous slot's.
- The top level holds the FSM, `count`, the handshakes and output packing.

## Test plan
- K=3, frame distances 50,20,80,10,30 (last on 30), labels 1..5 → `out_dist`={10,20,30}, `out_label`={4,2,5}, `out_count`=3, `out_valid` one cycle after the last beat.
- Tie: frame 7,7,7,7 with labels 1,2,3,4 → labels {1,2,3}; the fourth beat is discarded.
- Short frame: single beat 0xFFFF_FFFF with label 9 and last → `out_count`=1, slot0=0xFFFF_FFFF/label 9, slots 1..2 all-ones/label 0.
- Backpressure: hold `out_ready`=0 for 5 cycles in EMIT → outputs stable, `in_ready`=0, no beat accepted; then release → the next frame starts from an empty table, and back-to-back frames are correct.
- Reset mid-frame: insert 40,5, assert `ap_rst_n`=0 asynchronously between edges → outputs are immediately at reset values; then frame 60(last) → result {60} with `out_count`=1.
- Random: 10k beats in random-length frames with random `in_valid` and `out_ready` → results match a reference model using stable sort with the first K taken.

Source files
------------

// File: rtl/update_knn_pkg.sv
// Shared types and defaults for the streaming top-K neighbour tracker.
package update_knn_pkg;

  localparam int K_DEFAULT       = 3;
  localparam int DIST_W_DEFAULT  = 32;
  localparam int LABEL_W_DEFAULT = 4;
  localparam int COUNT_W         = 4;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    EMIT = 1'b1
  } state_e;

  localparam logic [DIST_W_DEFAULT-1:0] DIST_EMPTY = {DIST_W_DEFAULT{1'b1}};

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] cnt,
                                                 input logic [COUNT_W-1:0] lim);
    logic [COUNT_W-1:0] res;
    if (cnt >= lim) begin
      res = lim;
    end else begin
      res = cnt + {{(COUNT_W-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

endpackage

// File: rtl/update_knn_topk_slot.sv
// One entry of the sorted table: compare, then hold / shift-in / take-new.
module update_knn_topk_slot
  import update_knn_pkg::*;
#(
  parameter int                DIST_W  = DIST_W_DEFAULT,
  parameter int                LABEL_W = LABEL_W_DEFAULT,
  parameter logic [DIST_W-1:0] EMPTY   = {DIST_W{1'b1}}
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               accept_i,
  input  logic               clear_i,
  input  logic               valid_i,
  input  logic               prev_le_i,
  input  logic [DIST_W-1:0]  in_dist_i,
  input  logic [LABEL_W-1:0] in_label_i,
  input  logic [DIST_W-1:0]  prev_dist_i,
  input  logic [LABEL_W-1:0] prev_label_i,
  output logic               le_o,
  output logic [DIST_W-1:0]  dist_o,
  output logic [LABEL_W-1:0] label_o
);

  logic [DIST_W-1:0]  dist_q, dist_d;
  logic [LABEL_W-1:0] label_q, label_d;
  logic               take_new_s, shift_s;

  // Valid slots form a sorted prefix, so le bits read 1..1 0..0 across the table.
  assign le_o       = valid_i && (dist_q <= in_dist_i);
  assign take_new_s = accept_i && !le_o && prev_le_i;
  assign shift_s    = accept_i && !le_o && !prev_le_i;

  always_comb begin
    dist_d  = dist_q;
    label_d = label_q;
    if (clear_i) begin
      dist_d  = EMPTY;
      label_d = {LABEL_W{1'b0}};
    end else if (take_new_s) begin
      dist_d  = in_dist_i;
      label_d = in_label_i;
    end else if (shift_s) begin
      dist_d  = prev_dist_i;
      label_d = prev_label_i;
    end else begin
      dist_d  = dist_q;
      label_d = label_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dist_q  <= EMPTY;
      label_q <= {LABEL_W{1'b0}};
    end else begin
      dist_q  <= dist_d;
      label_q <= label_d;
    end
  end

  assign dist_o  = dist_q;
  assign label_o = label_q;

endmodule

// File: rtl/update_knn_topk.sv
// Streaming top-K smallest-distance tracker: sorted insert per beat, result
// held on out_* until the voting stage accepts it.
module update_knn_topk
  import update_knn_pkg::*;
#(
  parameter int K       = K_DEFAULT,
  parameter int DIST_W  = DIST_W_DEFAULT,
  parameter int LABEL_W = LABEL_W_DEFAULT
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DIST_W-1:0]    in_dist,
  input  logic [LABEL_W-1:0]   in_label,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [K*DIST_W-1:0]  out_dist,
  output logic [K*LABEL_W-1:0] out_label,
  output logic [3:0]           out_count
);

  localparam logic [DIST_W-1:0]  EMPTY = {DIST_W{DIST_EMPTY[0]}};
  localparam logic [COUNT_W-1:0] K_CNT = COUNT_W'(K);

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               accept_s, clear_s;
  logic [K:0]         le_s;
  logic [DIST_W-1:0]  slot_dist_s  [K];
  logic [LABEL_W-1:0] slot_label_s [K];
  logic [DIST_W-1:0]  prev_dist_s  [K];
  logic [LABEL_W-1:0] prev_label_s [K];

  assign accept_s = in_valid && in_ready_q;
  assign clear_s  = out_valid_q && out_ready;
  assign le_s[0]  = 1'b1;

  for (genvar i = 0; i < K; i++) begin : g_slot
    if (i == 0) begin : g_head
      assign prev_dist_s[i]  = EMPTY;
      assign prev_label_s[i] = {LABEL_W{1'b0}};
    end else begin : g_body
      assign prev_dist_s[i]  = slot_dist_s[i-1];
      assign prev_label_s[i] = slot_label_s[i-1];
    end

    update_knn_topk_slot #(
      .DIST_W  (DIST_W),
      .LABEL_W (LABEL_W),
      .EMPTY   (EMPTY)
    ) u_slot (
      .clk_i        (ap_clk),
      .rst_n_i      (ap_rst_n),
      .accept_i     (accept_s),
      .clear_i      (clear_s),
      .valid_i      (COUNT_W'(i) < count_q),
      .prev_le_i    (le_s[i]),
      .in_dist_i    (in_dist),
      .in_label_i   (in_label),
      .prev_dist_i  (prev_dist_s[i]),
      .prev_label_i (prev_label_s[i]),
      .le_o         (le_s[i+1]),
      .dist_o       (slot_dist_s[i]),
      .label_o      (slot_label_s[i])
    );

    assign out_dist[i*DIST_W +: DIST_W]    = slot_dist_s[i];
    assign out_label[i*LABEL_W +: LABEL_W] = slot_label_s[i];
  end

  // A beat lands unless every slot already holds a distance <= it.
  always_comb begin
    if (clear_s) begin
      count_d = {COUNT_W{1'b0}};
    end else if (accept_s && !le_s[K]) begin
      count_d = sat_inc(count_q, K_CNT);
    end else begin
      count_d = count_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (accept_s && in_last) begin
          state_d = EMIT;
        end else begin
          state_d = RUN;
        end
      end
      EMIT: begin
        if (clear_s) begin
          state_d = RUN;
        end else begin
          state_d = EMIT;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    case (state_d)
      RUN:     in_ready_d  = 1'b1;
      EMIT:    out_valid_d = 1'b1;
      default: begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= RUN;
      count_q     <= {COUNT_W{1'b0}};
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_count = count_q;

endmodule

// File: tb/tb_update_knn_topk.sv
// Bench for update_knn_topk: queue-and-stable-sort reference model checked every
// cycle, plus literal expectations for the hand-worked frames.
module tb_update_knn_topk;

  localparam int K  = 3;
  localparam int DW = 32;
  localparam int LW = 4;

  logic            ap_clk = 1'b0;
  logic            ap_rst_n;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DW-1:0]   in_dist = '0;
  logic [LW-1:0]   in_label = '0;
  logic            in_last = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [K*DW-1:0] out_dist;
  logic [K*LW-1:0] out_label;
  logic [3:0]      out_count;

  update_knn_topk #(.K(K), .DIST_W(DW), .LABEL_W(LW)) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_dist   (in_dist),
    .in_label  (in_label),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_dist  (out_dist),
    .out_label (out_label),
    .out_count (out_count)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [LW-1:0] l;
  } ent_t;

  ent_t fq[$];
  bit   m_en     = 1'b0;
  bit   m_emit   = 1'b0;
  int   checks   = 0;
  int   errors   = 0;
  int   accepted = 0;

  localparam logic [K*DW-1:0] ALL1 = {(K*DW){1'b1}};

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected table = frame beats stably sorted by distance, first K kept.
  function automatic void model_out(output logic [K*DW-1:0] d, output logic [K*LW-1:0] l,
                                    output logic [3:0] c);
    ent_t a[$];
    ent_t t;
    a = fq;
    for (int i = 0; i < a.size(); i++)
      for (int j = 0; j + 1 < a.size() - i; j++)
        if (a[j].d > a[j+1].d) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    for (int s = 0; s < K; s++) begin
      if (s < a.size()) begin
        d[s*DW +: DW] = a[s].d;
        l[s*LW +: LW] = a[s].l;
      end else begin
        d[s*DW +: DW] = {DW{1'b1}};
        l[s*LW +: LW] = {LW{1'b0}};
      end
    end
    c = (a.size() < K) ? 4'(a.size()) : 4'(K);
  endfunction

  initial begin
    logic [K*DW-1:0] ed;
    logic [K*LW-1:0] el;
    logic [3:0]      ec;
    forever begin
      @(negedge ap_clk);
      if (m_en) begin
        model_out(ed, el, ec);
        chk("m_in_ready",  128'(in_ready),  128'(!m_emit));
        chk("m_out_valid", 128'(out_valid), 128'(m_emit));
        chk("m_out_count", 128'(out_count), 128'(ec));
        chk("m_out_dist",  128'(out_dist),  128'(ed));
        chk("m_out_label", 128'(out_label), 128'(el));
        if (!m_emit && in_valid) begin
          fq.push_back('{in_dist, in_label});
          accepted++;
          if (in_last) m_emit = 1'b1;
        end else if (m_emit && out_ready) begin
          fq.delete();
          m_emit = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic [LW-1:0] l, input logic last);
    bit done = 1'b0;
    in_valid = 1'b1; in_dist = d; in_label = l; in_last = last;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge ap_clk);
      if (in_ready) done = 1'b1;
      @(posedge ap_clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("send_accepted", 128'(done), 128'(1));
  endtask

  task automatic wait_out(output int lat);
    bit seen = 1'b0;
    lat = -1;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge ap_clk);
      if (out_valid) begin
        seen = 1'b1;
        lat  = n;
      end
    end
  endtask

  task automatic release_out;
    @(posedge ap_clk); #1 out_ready = 1'b1;
    @(posedge ap_clk); #1 out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [K*DW-1:0] cap_d;
    logic [K*LW-1:0] cap_l;
    int cyc;

    ap_rst_n = 1'b1;
    #1 ap_rst_n = 1'b0;
    #2;
    chk("rst_in_ready",  128'(in_ready),  128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_count", 128'(out_count), 128'(0));
    chk("rst_out_dist",  128'(out_dist),  128'(ALL1));
    chk("rst_out_label", 128'(out_label), 128'(0));
    @(posedge ap_clk); @(posedge ap_clk); #1 ap_rst_n = 1'b1;
    @(posedge ap_clk); #1 m_en = 1'b1;
    chk("post_rst_in_ready", 128'(in_ready), 128'(1));

    // Basic frame.
    send(32'd50, 4'd1, 1'b0); send(32'd20, 4'd2, 1'b0); send(32'd80, 4'd3, 1'b0);
    send(32'd10, 4'd4, 1'b0); send(32'd30, 4'd5, 1'b1);
    wait_out(lat);
    chk("basic_latency", 128'(lat), 128'(0));
    chk("basic_dist",  128'(out_dist),  128'({32'd30, 32'd20, 32'd10}));
    chk("basic_label", 128'(out_label), 128'({4'd5, 4'd2, 4'd4}));
    chk("basic_count", 128'(out_count), 128'(3));
    release_out();

    // Ties: older sample wins.
    send(32'd7, 4'd1, 1'b0); send(32'd7, 4'd2, 1'b0);
    send(32'd7, 4'd3, 1'b0); send(32'd7, 4'd4, 1'b1);
    wait_out(lat);
    chk("tie_latency", 128'(lat), 128'(0));
    chk("tie_dist",  128'(out_dist),  128'({32'd7, 32'd7, 32'd7}));
    chk("tie_label", 128'(out_label), 128'({4'd3, 4'd2, 4'd1}));
    chk("tie_count", 128'(out_count), 128'(3));
    release_out();

    // Short frame with an all-ones distance.
    send(32'hFFFF_FFFF, 4'd9, 1'b1);
    wait_out(lat);
    chk("short_dist",  128'(out_dist),  128'(ALL1));
    chk("short_label", 128'(out_label), 128'({4'd0, 4'd0, 4'd9}));
    chk("short_count", 128'(out_count), 128'(1));
    release_out();

    // Backpressure: beats offered during EMIT must be ignored.
    send(32'd9, 4'd1, 1'b0); send(32'd4, 4'd2, 1'b1);
    wait_out(lat);
    chk("bp_dist",  128'(out_dist),  128'({32'hFFFF_FFFF, 32'd9, 32'd4}));
    chk("bp_label", 128'(out_label), 128'({4'd0, 4'd1, 4'd2}));
    chk("bp_count", 128'(out_count), 128'(2));
    cap_d = out_dist; cap_l = out_label;
    for (int i = 0; i < 5; i++) begin
      @(posedge ap_clk); #1;
      in_valid = 1'b1; in_dist = 32'd1; in_label = 4'd7; in_last = 1'b1;
      @(negedge ap_clk);
      chk("bp_hold_dist",  128'(out_dist),  128'(cap_d));
      chk("bp_hold_label", 128'(out_label), 128'(cap_l));
      chk("bp_in_ready",   128'(in_ready),  128'(0));
      chk("bp_out_valid",  128'(out_valid), 128'(1));
    end
    @(posedge ap_clk); #1 in_valid = 1'b0; in_last = 1'b0;
    release_out();
    send(32'd100, 4'd7, 1'b1);
    wait_out(lat);
    chk("after_bp_dist",  128'(out_dist),  128'({32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100}));
    chk("after_bp_count", 128'(out_count), 128'(1));
    release_out();

    // Asynchronous reset in the middle of a frame.
    send(32'd40, 4'd1, 1'b0); send(32'd5, 4'd2, 1'b0);
    #2 m_en = 1'b0; ap_rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_out_count", 128'(out_count), 128'(0));
    chk("mid_rst_out_dist",  128'(out_dist),  128'(ALL1));
    chk("mid_rst_out_label", 128'(out_label), 128'(0));
    chk("mid_rst_in_ready",  128'(in_ready),  128'(0));
    @(posedge ap_clk); #1 ap_rst_n = 1'b1;
    fq.delete(); m_emit = 1'b0;
    @(posedge ap_clk); #1 m_en = 1'b1;
    send(32'd60, 4'd6, 1'b1);
    wait_out(lat);
    chk("rst_frame_dist",  128'(out_dist),  128'({32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd60}));
    chk("rst_frame_label", 128'(out_label), 128'({4'd0, 4'd0, 4'd6}));
    chk("rst_frame_count", 128'(out_count), 128'(1));
    release_out();

    // Randomized traffic checked by the model on every cycle.
    accepted = 0;
    cyc = 0;
    while (accepted < 10000 && cyc < 60000) begin
      @(posedge ap_clk); #1;
      cyc++;
      in_valid = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 3))
        0:       in_dist = DW'($urandom_range(0, 7));
        1:       in_dist = $urandom;
        2:       in_dist = {DW{1'b1}};
        default: in_dist = DW'($urandom_range(0, 1000));
      endcase
      in_label  = LW'($urandom_range(0, 15));
      in_last   = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 1) == 1);
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge ap_clk);
    #1 out_ready = 1'b0;
    chk("random_budget", 128'(accepted >= 10000), 128'(1));
    @(negedge ap_clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
